// File: rtl/col2im_acc.sv
// rtl/col2im_acc.sv - column-matrix scatter-accumulate back into a C x H x W image buffer
module col2im_acc #(
    parameter int IMG_C       = 1,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int FILTER_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] COL_BASE = 'h2000,
    parameter logic [ADDR_WIDTH-1:0] IMG_BASE = 'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_rd,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic [ACC_WIDTH-1:0]  data_wr,
    output logic                  mem_wr_en,
    output logic                  busy,
    output logic                  done
);
    localparam int K     = FILTER_SIZE;
    localparam int PAD   = (K - 1) / 2;
    localparam int N_IMG = IMG_C * IMG_H * IMG_W;
    localparam int N_COL = N_IMG * K * K;
    localparam int CNT_W = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int IDX_W = (N_IMG > 1) ? $clog2(N_IMG) : 1;
    localparam int HW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int CW    = (IMG_C > 1) ? $clog2(IMG_C) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [HW-1:0]        h;
    logic [WW-1:0]        w;
    logic [CW-1:0]        c;
    logic [KW-1:0]        fh, fw;
    logic                 pend_valid;
    logic [IDX_W-1:0]     pend_idx;
    logic [ACC_WIDTH-1:0] acc [N_IMG];

    int                   ih, iw;
    logic                 tgt_valid;
    logic [IDX_W-1:0]     tgt_idx;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] acc0_fwd;
    logic [IDX_W-1:0]     wnext;

    // Target pixel of the element currently on addr_rd; it is consumed a cycle later.
    always_comb begin
        ih        = int'(h) + int'(fh) - PAD;
        iw        = int'(w) + int'(fw) - PAD;
        tgt_valid = (ih >= 0) && (ih < IMG_H) && (iw >= 0) && (iw < IMG_W);
        tgt_idx   = IDX_W'(int'(c) * (IMG_H * IMG_W) + ih * IMG_W + iw);
    end

    assign acc_sum  = acc[pend_idx] + ACC_WIDTH'(data_rd);
    // The DRAIN update of acc[0] lands on the same edge that loads the first write word.
    assign acc0_fwd = (pend_valid && pend_idx == '0) ? acc_sum : acc[0];
    assign wnext    = IDX_W'(cnt) + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            acc[IDX_W'(cnt)] <= '0;
        else if ((state == S_READ || state == S_DRAIN) && pend_valid)
            acc[pend_idx] <= acc_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            h          <= '0;
            w          <= '0;
            c          <= '0;
            fh         <= '0;
            fw         <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            addr_rd    <= COL_BASE;
            addr_wr    <= IMG_BASE;
            data_wr    <= '0;
            mem_wr_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pend_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (cnt == CNT_W'(N_IMG - 1)) begin
                        state   <= S_READ;
                        cnt     <= '0;
                        addr_rd <= COL_BASE;
                        h       <= '0;
                        w       <= '0;
                        c       <= '0;
                        fh      <= '0;
                        fw      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_READ: begin
                    pend_valid <= tgt_valid;
                    pend_idx   <= tgt_idx;
                    if (cnt == CNT_W'(N_COL - 1)) begin
                        state <= S_DRAIN;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        addr_rd <= addr_rd + 1'b1;
                        if (fw != KW'(K - 1)) begin
                            fw <= fw + 1'b1;
                        end else begin
                            fw <= '0;
                            if (fh != KW'(K - 1)) begin
                                fh <= fh + 1'b1;
                            end else begin
                                fh <= '0;
                                if (c != CW'(IMG_C - 1)) begin
                                    c <= c + 1'b1;
                                end else begin
                                    c <= '0;
                                    if (w != WW'(IMG_W - 1)) begin
                                        w <= w + 1'b1;
                                    end else begin
                                        w <= '0;
                                        h <= h + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    state     <= S_WRITE;
                    cnt       <= '0;
                    mem_wr_en <= 1'b1;
                    addr_wr   <= IMG_BASE;
                    data_wr   <= acc0_fwd;
                end
                S_WRITE: begin
                    if (cnt == CNT_W'(N_IMG - 1)) begin
                        state     <= S_DONE;
                        mem_wr_en <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        addr_wr <= addr_wr + 1'b1;
                        data_wr <= acc[wnext];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_col2im_acc.sv
// tb/tb_col2im_acc.sv - directed vector bench for col2im_acc across four parameter sets
module tb_col2im_acc;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn [4];
    logic        st [4];
    logic [7:0]  dr [4];
    logic [31:0] ar [4];
    logic [31:0] aw [4];
    logic [15:0] dw [4];
    logic        we [4];
    logic        bz [4];
    logic        dn [4];
    logic [10:0] dw_c;
    logic        pat_a;

    logic [7:0]  img    [64];
    logic [7:0]  colmem [1024];
    logic [15:0] cap    [4][64];
    logic [15:0] ref_ones [16];
    int          nwr [4];
    int          ord_err [4];
    int          nvec = 0;
    int          nmis = 0;

    // u_a: 4x4 K3, u_b: 2ch 4x4 K1, u_c: 4x4 K3 11-bit acc, u_d: 8x8 K3 round trip
    col2im_acc #(.IMG_C(1), .IMG_W(4), .IMG_H(4), .FILTER_SIZE(3)) u_a (
        .clk(clk), .rst_n(rn[0]), .start(st[0]), .data_rd(dr[0]), .addr_rd(ar[0]),
        .addr_wr(aw[0]), .data_wr(dw[0]), .mem_wr_en(we[0]), .busy(bz[0]), .done(dn[0]));
    col2im_acc #(.IMG_C(2), .IMG_W(4), .IMG_H(4), .FILTER_SIZE(1)) u_b (
        .clk(clk), .rst_n(rn[1]), .start(st[1]), .data_rd(dr[1]), .addr_rd(ar[1]),
        .addr_wr(aw[1]), .data_wr(dw[1]), .mem_wr_en(we[1]), .busy(bz[1]), .done(dn[1]));
    col2im_acc #(.IMG_C(1), .IMG_W(4), .IMG_H(4), .FILTER_SIZE(3), .ACC_WIDTH(11)) u_c (
        .clk(clk), .rst_n(rn[2]), .start(st[2]), .data_rd(dr[2]), .addr_rd(ar[2]),
        .addr_wr(aw[2]), .data_wr(dw_c), .mem_wr_en(we[2]), .busy(bz[2]), .done(dn[2]));
    col2im_acc #(.IMG_C(1), .IMG_W(8), .IMG_H(8), .FILTER_SIZE(3)) u_d (
        .clk(clk), .rst_n(rn[3]), .start(st[3]), .data_rd(dr[3]), .addr_rd(ar[3]),
        .addr_wr(aw[3]), .data_wr(dw[3]), .mem_wr_en(we[3]), .busy(bz[3]), .done(dn[3]));

    assign dw[2] = {5'b0, dw_c};

    always_ff @(posedge clk) begin
        dr[0] <= pat_a ? 8'hFF : 8'h01;
        dr[1] <= ar[1][7:0];
        dr[2] <= 8'hFF;
        dr[3] <= colmem[ar[3][9:0]];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                if (aw[i] !== 32'(nwr[i]) || !bz[i]) ord_err[i]++;
                cap[i][aw[i][5:0]] = dw[i];
                nwr[i]++;
            end
        end
    end

    typedef struct {
        int tag;
        int inst;
        int idx;
        int exp;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tbl(input int tag);
        for (int k = 0; k < 19; k++)
            if (tbl[k].tag == tag)
                chk($sformatf("vec%0d_pix%0d", k, tbl[k].idx),
                    32'(cap[tbl[k].inst][tbl[k].idx]), 32'(tbl[k].exp));
    endtask

    task automatic run(input int i, input int p1, input int p2, input int exp_lat, input int exp_n);
        int n;
        n = 0;
        nwr[i] = 0;
        ord_err[i] = 0;
        @(negedge clk);
        st[i] = 1'b1;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            st[i] = (n == p1) || (n == p2);
            if (n == 1) begin
                chk("done_low_after_start", 32'(dn[i]), 32'd0);
                chk("busy_after_start", 32'(bz[i]), 32'd1);
            end
            if (dn[i]) break;
        end
        st[i] = 1'b0;
        chk($sformatf("latency%0d", i), 32'(n), 32'(exp_lat));
        chk($sformatf("write_count%0d", i), 32'(nwr[i]), 32'(exp_n));
        chk($sformatf("write_order%0d", i), 32'(ord_err[i]), 32'd0);
    endtask

    initial begin
        int e, p, f, y, x, sy, sx, ry, cx;
        tbl = '{
            '{0, 0, 0, 4},    '{0, 0, 1, 6},    '{0, 0, 5, 9},    '{0, 0, 15, 4},
            '{0, 0, 12, 4},   '{0, 0, 7, 6},
            '{1, 1, 0, 0},    '{1, 1, 1, 2},    '{1, 1, 5, 10},   '{1, 1, 16, 1},
            '{1, 1, 31, 31},
            '{2, 0, 0, 1020}, '{2, 0, 1, 1530}, '{2, 0, 5, 2295}, '{2, 0, 10, 2295},
            '{3, 2, 5, 247},  '{3, 2, 0, 1020}, '{3, 2, 1, 1530}, '{3, 2, 10, 247}
        };
        for (int k = 0; k < 64; k++) img[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 1024; k++) colmem[k] = 8'h00;
        for (e = 0; e < 576; e++) begin
            p = e / 9;
            f = e % 9;
            sy = p / 8 + f / 3 - 1;
            sx = p % 8 + f % 3 - 1;
            if (sy >= 0 && sy < 8 && sx >= 0 && sx < 8) colmem[e] = img[sy * 8 + sx];
        end
        for (int i = 0; i < 4; i++) begin
            rn[i] = 1'b0;
            st[i] = 1'b0;
            nwr[i] = 0;
            ord_err[i] = 0;
        end
        pat_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr_rd", ar[0], 32'h2000);
        chk("rst_addr_wr", aw[0], 32'h0);
        chk("rst_data_wr", 32'(dw[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_wr_en%0d", i), 32'(we[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(bz[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(dn[i]), 32'd0);
        end
        for (int i = 0; i < 4; i++) rn[i] = 1'b1;

        run(0, 0, 0, 178, 16);
        check_tbl(0);
        for (int k = 0; k < 16; k++) ref_ones[k] = cap[0][k];

        run(1, 0, 0, 98, 32);
        check_tbl(1);

        pat_a = 1'b1;
        run(0, 0, 0, 178, 16);
        check_tbl(2);

        run(2, 0, 0, 178, 16);
        check_tbl(3);

        run(3, 0, 0, 706, 64);
        for (y = 0; y < 8; y++) begin
            for (x = 0; x < 8; x++) begin
                ry = 1 + ((y > 0) ? 1 : 0) + ((y < 7) ? 1 : 0);
                cx = 1 + ((x > 0) ? 1 : 0) + ((x < 7) ? 1 : 0);
                chk($sformatf("roundtrip_%0d_%0d", y, x), 32'(cap[3][y * 8 + x]),
                    32'(16'(int'(img[y * 8 + x]) * ry * cx)));
            end
        end

        // Abort in the middle of READ, then expect a clean rerun.
        pat_a = 1'b0;
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_read_busy", 32'(bz[0]), 32'd1);
        rn[0] = 1'b0;
        @(negedge clk);
        chk("abort_addr_rd", ar[0], 32'h2000);
        chk("abort_addr_wr", aw[0], 32'h0);
        chk("abort_data_wr", 32'(dw[0]), 32'd0);
        chk("abort_wr_en", 32'(we[0]), 32'd0);
        chk("abort_busy", 32'(bz[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        rn[0] = 1'b1;
        for (int k = 0; k < 16; k++) cap[0][k] = 16'hDEAD;
        run(0, 0, 0, 178, 16);
        check_tbl(0);

        // Start pulses during READ (50) and WRITE (170) must be ignored.
        for (int k = 0; k < 16; k++) cap[0][k] = 16'hDEAD;
        run(0, 50, 170, 178, 16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("rerun_pix%0d", k), 32'(cap[0][k]), 32'(ref_ones[k]));
        chk("done_held", 32'(dn[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
